// File: rtl/wb_write_queue.sv
`default_nettype none
// ============================================================================
// Module  : wb_write_queue
// Brief   : In-order writeback FIFO feeding the register file write port from
//           the load unit (priority) and the ALU, with decode hazard lookup.
// Revision: 1.0
// ============================================================================
module wb_write_queue #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5,
  parameter int DEPTH         = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       alu_valid,
  output logic                       alu_ready,
  input  logic [ADDRESS_WIDTH-1:0]   alu_dest,
  input  logic [DATA_WIDTH-1:0]      alu_data,
  input  logic                       ld_valid,
  output logic                       ld_ready,
  input  logic [ADDRESS_WIDTH-1:0]   ld_dest,
  input  logic [DATA_WIDTH-1:0]      ld_data,
  output logic                       rg_wrt_en,
  output logic [ADDRESS_WIDTH-1:0]   rg_wrt_dest,
  output logic [DATA_WIDTH-1:0]      rg_wrt_data,
  input  logic [ADDRESS_WIDTH-1:0]   chk_addr1,
  input  logic [ADDRESS_WIDTH-1:0]   chk_addr2,
  output logic                       chk_pend1,
  output logic                       chk_pend2,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [ADDRESS_WIDTH-1:0] dest_mem [DEPTH];
  logic [DATA_WIDTH-1:0]    data_mem [DEPTH];
  logic [PW-1:0]            wr_ptr;
  logic [PW-1:0]            rd_ptr;

  logic                     full;
  logic                     empty;
  logic                     push_ld;
  logic                     push_alu;
  logic                     push;
  logic                     pop;
  logic [ADDRESS_WIDTH-1:0] push_dest;
  logic [DATA_WIDTH-1:0]    push_data;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign ld_ready  = !full;
  assign alu_ready = !full && !ld_valid;

  // Register x0 is never written: the handshake completes but nothing is queued.
  assign push_ld   = ld_valid && ld_ready && (ld_dest != '0);
  assign push_alu  = alu_valid && alu_ready && (alu_dest != '0);
  assign push      = push_ld || push_alu;
  assign push_dest = push_ld ? ld_dest : alu_dest;
  assign push_data = push_ld ? ld_data : alu_data;
  assign pop       = !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dest_mem[i] <= '0;
        data_mem[i] <= '0;
      end
    end else begin
      if (push) begin
        dest_mem[wr_ptr] <= push_dest;
        data_mem[wr_ptr] <= push_data;
        wr_ptr           <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (!push && pop) begin
        count <= count - CW'(1);
      end
    end
  end

  assign rg_wrt_en   = !empty;
  assign rg_wrt_dest = empty ? '0 : dest_mem[rd_ptr];
  assign rg_wrt_data = empty ? '0 : data_mem[rd_ptr];

  // An entry is occupied when its distance from the head is below count.
  always_comb begin
    logic [PW-1:0] offset;
    chk_pend1 = 1'b0;
    chk_pend2 = 1'b0;
    offset    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset = PW'(i) - rd_ptr;
      if ({1'b0, offset} < (PW+1)'(count)) begin
        if ((chk_addr1 != '0) && (dest_mem[i] == chk_addr1)) chk_pend1 = 1'b1;
        if ((chk_addr2 != '0) && (dest_mem[i] == chk_addr2)) chk_pend2 = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_write_queue.sv
`default_nettype none
// Testbench for wb_write_queue: directed scenarios plus random traffic checked
// against a queue-based reference model.
module tb_wb_write_queue;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [AW-1:0] dest;
    logic [DW-1:0] data;
  } entry_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          alu_valid, alu_ready, ld_valid, ld_ready;
  logic [AW-1:0] alu_dest, ld_dest, chk_addr1, chk_addr2, rg_wrt_dest;
  logic [DW-1:0] alu_data, ld_data, rg_wrt_data;
  logic          rg_wrt_en, chk_pend1, chk_pend2;
  logic [$clog2(DEPTH+1)-1:0] count;

  int tests = 0;
  int fails = 0;
  entry_t q[$];
  int writes = 0;

  wb_write_queue #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_dest(alu_dest), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_dest(ld_dest), .ld_data(ld_data),
    .rg_wrt_en(rg_wrt_en), .rg_wrt_dest(rg_wrt_dest), .rg_wrt_data(rg_wrt_data),
    .chk_addr1(chk_addr1), .chk_addr2(chk_addr2),
    .chk_pend1(chk_pend1), .chk_pend2(chk_pend2), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit model_pend(input logic [AW-1:0] a);
    if (a == 0) return 1'b0;
    foreach (q[i]) if (q[i].dest == a) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check_all();
    bit room;
    room = (q.size() < DEPTH);
    check("ld_ready", ld_ready, room);
    check("alu_ready", alu_ready, room && !ld_valid);
    check("count", count, q.size());
    check("wrt_en", rg_wrt_en, q.size() != 0);
    check("wrt_dest", rg_wrt_dest, (q.size() != 0) ? q[0].dest : '0);
    check("wrt_data", rg_wrt_data, (q.size() != 0) ? q[0].data : '0);
    check("pend1", chk_pend1, model_pend(chk_addr1));
    check("pend2", chk_pend2, model_pend(chk_addr2));
  endtask

  // Inputs are set just after a negedge; check, then apply the posedge in the model.
  task automatic tick();
    bit acc_ld, acc_alu;
    #1;
    check_all();
    @(posedge clk);
    acc_ld  = ld_valid && (q.size() < DEPTH);
    acc_alu = alu_valid && !ld_valid && (q.size() < DEPTH);
    if (q.size() != 0) begin
      void'(q.pop_front());
      writes++;
    end
    if (acc_ld && ld_dest != 0) q.push_back('{ld_dest, ld_data});
    else if (acc_alu && alu_dest != 0) q.push_back('{alu_dest, alu_data});
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    alu_valid = 0; alu_dest = 0; alu_data = 0;
    ld_valid = 0; ld_dest = 0; ld_data = 0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    chk_addr1 = 0; chk_addr2 = 0;
    repeat (2) @(negedge clk);
    #1;
    check_all();
    rst = 1'b0;

    // Idle after reset
    tick();

    // Single ALU write, then empty again
    alu_valid = 1; alu_dest = 5; alu_data = 32'hDEADBEEF;
    tick();
    idle_inputs();
    #1;
    check("t2_en", rg_wrt_en, 1'b1);
    check("t2_data", rg_wrt_data, 64'hDEADBEEF);
    tick();
    tick();

    // Load wins over ALU; ALU taken the following cycle
    ld_valid = 1; ld_dest = 3; ld_data = 32'h11;
    alu_valid = 1; alu_dest = 4; alu_data = 32'h22;
    tick();
    ld_valid = 0;
    tick();
    idle_inputs();
    #1;
    check("t3_dest", rg_wrt_dest, 64'd4);
    tick();
    tick();

    // Back-to-back loads
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1; ld_dest = AW'(10 + i); ld_data = 32'hA000 + i;
      tick();
    end
    idle_inputs();
    tick();
    tick();

    // x0 is dropped
    alu_valid = 1; alu_dest = 0; alu_data = 32'hFFFFFFFF;
    tick();
    idle_inputs();
    #1;
    check("t5_en", rg_wrt_en, 1'b0);
    tick();

    // Hazard lookup on reg7
    chk_addr1 = 7; chk_addr2 = 0;
    alu_valid = 1; alu_dest = 7; alu_data = 32'h77;
    tick();
    idle_inputs();
    #1;
    check("t6_pend", chk_pend1, 1'b1);
    tick();
    #1;
    check("t6_clear", chk_pend1, 1'b0);
    tick();

    // Asynchronous reset with an entry queued
    ld_valid = 1; ld_dest = 9; ld_data = 32'h99;
    tick();
    idle_inputs();
    #2;
    rst = 1'b1;
    #1;
    check("rst_count", count, 0);
    check("rst_en", rg_wrt_en, 1'b0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      ld_valid  = ($urandom_range(0, 2) == 0);
      ld_dest   = AW'($urandom_range(0, 7));
      ld_data   = $urandom;
      alu_valid = ($urandom_range(0, 1) == 0);
      alu_dest  = AW'($urandom_range(0, 7));
      alu_data  = $urandom;
      chk_addr1 = AW'($urandom_range(0, 7));
      chk_addr2 = AW'($urandom_range(0, 7));
      tick();
    end
    idle_inputs();
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
`default_nettype wire
